muldiv_ctrl: RTL

// Multi-cycle multiply/divide sequencer with architectural HI/LO registers for the MIPS core.
// The execute stage issues MULT/MULTU/DIV/DIVU here instead of into the single-cycle ALU.
// The block stalls the pipeline while busy, runs an iterative radix-2 divider, and holds HI/LO.
// It also serves MTHI/MTLO writes and an exception flush.

---
 rtl/muldiv_ctrl_pkg.sv | 29 ++
 rtl/muldiv_ctrl_if.sv | 42 ++++
 rtl/muldiv_ctrl_div_step.sv | 29 ++
 rtl/muldiv_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and defaults for the multiply/divide sequencer.
package muldiv_ctrl_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_MUL_LAT = 2;

  // Sequencer states; also exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Local operation select derived from the op_mul/op_div request flags.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_MUL  = 2'd1,
    OP_DIV  = 2'd2
  } op_sel_t;

  // Multiply wins if both flags are (illegally) set; no flag means no operation.
  function automatic op_sel_t op_decode(input logic mul, input logic div);
    if (mul)      return OP_MUL;
    else if (div) return OP_DIV;
    else          return OP_NONE;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> mul/div sequencer bus.
//
// Handshake: the EX stage raises start with one op flag and the operands for a
// cycle. The request is taken at the rising edge when the sequencer is idle, no
// flush is present and no MTHI/MTLO write coincides. stall acts as the inverse of
// ready: while it is high the EX stage must hold (it is frozen), and the cycle it
// drops the result is already architecturally visible on hi/lo. done pulses for
// one cycle right after a mul/div result is written.
interface muldiv_ctrl_if
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic             op_mul;
  logic             op_div;
  logic             op_uns;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             flush;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline (EX) side.
  modport master (
    output start, op_mul, op_div, op_uns, src1, src2, mthi, mtlo, wdata, flush,
    input  stall, done, hi, lo
  );

  // Sequencer side.
  modport slave (
    input  start, op_mul, op_div, op_uns, src1, src2, mthi, mtlo, wdata, flush,
    output stall, done, hi, lo
  );

endinterface

// File: rtl/muldiv_ctrl_div_step.sv
// One radix-2 restoring division iteration, MSB of the dividend first.
// The quotient register doubles as the dividend shift register: its MSB feeds
// the partial remainder and the new quotient bit enters at the LSB.
module muldiv_ctrl_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_sub;
  logic             w_ge;

  // Shift the next dividend bit in and try to subtract the divisor.
  // When the subtraction succeeds the result is below the divisor, so the
  // WIDTH-bit modular difference is exact.
  always_comb begin
    w_shift = {i_rem, i_quot[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, i_dvsr});
    w_sub   = w_shift[WIDTH-1:0] - i_dvsr;
    o_rem   = w_ge ? w_sub : w_shift[WIDTH-1:0];
    o_quot  = {i_quot[WIDTH-2:0], w_ge};
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer holding the architectural HI/LO pair.
// Multiply: product formed once from operand magnitudes at the accept edge and
// held until the MUL countdown expires. Divide: one restoring step per cycle on
// magnitudes, signs fixed up when the final step is written to HI/LO.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic          clk,
  input  logic          resetn,
  muldiv_ctrl_if.slave  bus,
  output state_t        o_dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;

  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_prod;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quot;
  logic [WIDTH-1:0]     r_dvsr;
  logic                 r_dvsr_zero;
  logic                 r_neg_q;
  logic                 r_neg_r;

  op_sel_t              w_op_sel;
  logic                 w_signed;
  logic                 w_mtx;
  logic                 w_accept;
  logic                 w_accept_mul;
  logic                 w_accept_div;
  logic                 w_mtx_ok;
  logic                 w_cnt_zero;
  logic                 w_fin_mul;
  logic                 w_fin_div;
  logic                 w_dvsr_zero;
  logic [WIDTH-1:0]     w_mag1;
  logic [WIDTH-1:0]     w_mag2;
  logic [2*WIDTH-1:0]   w_prod_mag;
  logic [2*WIDTH-1:0]   w_prod_in;
  logic                 w_neg_q_in;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic [WIDTH-1:0]     w_quot_nxt;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [WIDTH-1:0]     w_quot_fix;
  logic                 w_stall;
  logic                 w_done;

  // Request decode, input priority (flush > mthi/mtlo > start) and operand prep.
  always_comb begin
    w_op_sel     = op_decode(bus.op_mul, bus.op_div);
    w_signed     = ~bus.op_uns;
    w_mtx        = bus.mthi | bus.mtlo;
    w_accept     = (r_state == ST_IDLE) & bus.start & (w_op_sel != OP_NONE)
                   & ~bus.flush & ~w_mtx;
    w_accept_mul = w_accept & (w_op_sel == OP_MUL);
    w_accept_div = w_accept & (w_op_sel == OP_DIV);
    w_mtx_ok     = ((r_state == ST_IDLE) | (r_state == ST_DONE)) & w_mtx & ~bus.flush;
    w_cnt_zero   = (r_cnt == '0);
    w_fin_mul    = (r_state == ST_MUL) & w_cnt_zero & ~bus.flush;
    w_fin_div    = (r_state == ST_DIV) & w_cnt_zero & ~bus.flush;
    w_dvsr_zero  = (bus.src2 == '0);
    w_mag1       = (w_signed & bus.src1[WIDTH-1]) ? -bus.src1 : bus.src1;
    w_mag2       = (w_signed & bus.src2[WIDTH-1]) ? -bus.src2 : bus.src2;
    w_neg_q_in   = w_signed & (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
    w_prod_mag   = {{WIDTH{1'b0}}, w_mag1} * {{WIDTH{1'b0}}, w_mag2};
    w_prod_in    = w_neg_q_in ? -w_prod_mag : w_prod_mag;
  end

  muldiv_ctrl_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem  (r_rem),
    .i_quot (r_quot),
    .i_dvsr (r_dvsr),
    .o_rem  (w_rem_nxt),
    .o_quot (w_quot_nxt)
  );

  // Sign fix-up of the final division step: quotient by sign difference,
  // remainder follows the dividend.
  always_comb begin
    w_quot_fix = r_neg_q ? -w_quot_nxt : w_quot_nxt;
    w_rem_fix  = r_neg_r ? -w_rem_nxt  : w_rem_nxt;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; flush returns to IDLE from any state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_mul)      w_state_nxt = ST_MUL;
        else if (w_accept_div) w_state_nxt = ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (bus.flush)       w_state_nxt = ST_IDLE;
        else if (w_cnt_zero) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: stall covers the issue cycle and the busy states; done marks DONE.
  always_comb begin
    w_stall = ((r_state == ST_IDLE) & bus.start & (bus.op_mul | bus.op_div) & ~bus.flush)
              | (r_state == ST_MUL) | (r_state == ST_DIV);
    w_done  = (r_state == ST_DONE);
  end

  assign bus.stall   = w_stall;
  assign bus.done    = w_done;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign o_dbg_state = r_state;

  // Busy countdown; a zero divisor loads 0 so the DIV state lasts one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)            r_cnt <= '0;
    else if (bus.flush)     r_cnt <= '0;
    else if (w_accept_mul)  r_cnt <= CNT_W'(MUL_LAT - 1);
    else if (w_accept_div)  r_cnt <= w_dvsr_zero ? '0 : CNT_W'(WIDTH - 1);
    else if (((r_state == ST_MUL) | (r_state == ST_DIV)) & ~w_cnt_zero)
                            r_cnt <= r_cnt - CNT_W'(1);
  end

  // Operand capture on accept and the per-cycle division iteration.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prod      <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_dvsr      <= '0;
      r_dvsr_zero <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
    end else if (w_accept) begin
      r_prod      <= w_prod_in;
      r_rem       <= '0;
      r_quot      <= w_mag1;
      r_dvsr      <= w_mag2;
      r_dvsr_zero <= w_dvsr_zero;
      r_neg_q     <= w_neg_q_in;
      r_neg_r     <= w_signed & bus.src1[WIDTH-1];
    end else if (r_state == ST_DIV) begin
      r_rem       <= w_rem_nxt;
      r_quot      <= w_quot_nxt;
    end
  end

  // Architectural HI/LO: mul/div results, else MTHI/MTLO in IDLE/DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fin_mul) begin
      r_hi <= r_prod[2*WIDTH-1:WIDTH];
      r_lo <= r_prod[WIDTH-1:0];
    end else if (w_fin_div) begin
      r_hi <= r_dvsr_zero ? '0 : w_rem_fix;
      r_lo <= r_dvsr_zero ? '0 : w_quot_fix;
    end else if (w_mtx_ok) begin
      if (bus.mthi) r_hi <= bus.wdata;
      if (bus.mtlo) r_lo <= bus.wdata;
    end
  end

endmodule
